// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
package ser_pkg;

    localparam int unsigned SER_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } state_e;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in, MSB-first serial-out stage feeding the sequence detector's w input.
// Define SER_PARITY_EN to append an even-parity bit after the data bits of every frame.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH      = SER_WIDTH_DEF,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned      CntW     = $clog2(WIDTH);
    localparam logic [CntW-1:0]  CntLast  = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] IdleWord = {WIDTH{IDLE_LEVEL}};

    state_e           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [CntW-1:0]  cnt_q;
    logic             w_valid_q;
    logic             frame_done_q;
    logic             last_bit;
    logic             xfer;

`ifdef SER_PARITY_EN
    logic parity_q;
    assign last_bit = (state_q == PARITY);
`else
    assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
`endif

    assign din_ready  = (state_q == IDLE) || last_bit;
    assign xfer       = din_valid && din_ready;
    // The MSB of the shift register is the bit on the wire, so w comes straight off a flop.
    assign w          = sreg_q[WIDTH-1];
    assign w_valid    = w_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sreg_q       <= IdleWord;
            cnt_q        <= '0;
            w_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else if (xfer) begin
            // Accepting is only possible in IDLE or on the final bit, which gives zero-gap reloads.
            state_q      <= SHIFT;
            sreg_q       <= din;
            cnt_q        <= CntLast;
            w_valid_q    <= 1'b1;
            frame_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q     <= ^din;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        sreg_q <= {sreg_q[WIDTH-2:0], IDLE_LEVEL};
                        cnt_q  <= cnt_q - CntW'(1);
`ifdef SER_PARITY_EN
                        frame_done_q <= 1'b0;
`else
                        frame_done_q <= (cnt_q == CntW'(1));
`endif
                    end else begin
`ifdef SER_PARITY_EN
                        state_q      <= PARITY;
                        sreg_q       <= {parity_q, IdleWord[WIDTH-2:0]};
                        frame_done_q <= 1'b1;
`else
                        state_q      <= IDLE;
                        sreg_q       <= IdleWord;
                        w_valid_q    <= 1'b0;
                        frame_done_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    // PARITY with no new word, or an illegal encoding: back to a clean idle.
                    state_q      <= IDLE;
                    sreg_q       <= IdleWord;
                    cnt_q        <= '0;
                    w_valid_q    <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-in, serial-out stage that feeds the single-bit `w` input of the FSM sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- Supports back-to-back words with no idle gap.
- Provides a `w_valid` qualifier and a `frame_done` pulse for downstream framing and debug.

Parameters:
WIDTH, 8, data word width in bits; legal range WIDTH >= 2
IDLE_LEVEL, 1'b0, value driven on `w` whenever no frame bit is being sent

Ports:
clk  input  1  single system clock; all flops on rising edge
reset_n  input  1  asynchronous, active-low reset
din  input  WIDTH  parallel word; sampled only on handshake
din_valid  input  1  upstream has a word on `din`
din_ready  output  1  block can accept a word this cycle
w  output  1  serial bit stream to the sequence detector; registered
w_valid  output  1  high while `w` carries a frame bit; registered
busy  output  1  high in any non-IDLE state
frame_done  output  1  one-cycle pulse during the last bit of a frame

Behaviour:
- Reset (reset_n low, async):
  - state = IDLE; shift register = all IDLE_LEVEL; bit counter = 0.
  - w = IDLE_LEVEL; w_valid = 0; busy = 0; frame_done = 0.
- Reset asserted mid-frame:
  - Frame aborted immediately; partial data discarded; no frame_done.
  - din_ready = 1 while in reset, but handshakes during reset are ignored.
- States (2-bit encoding): IDLE, SHIFT, PARITY (PARITY reachable only with the optional feature).
- Handshake: transfer when din_valid && din_ready at a rising edge.
  - din may change freely while no transfer occurs.
  - din_valid may assert or deassert in any cycle.
- din_ready (combinational from state):
  - 1 in IDLE.
  - 1 in the final-bit cycle of the frame (last SHIFT bit, or the PARITY cycle when the feature is enabled).
  - 0 otherwise.
- IDLE:
  - On transfer: load din into the shift register, counter = WIDTH-1, go to SHIFT.
  - The first bit (din[WIDTH-1]) appears on w in the cycle after the accepting edge. Latency is 1 cycle.
- SHIFT:
  - w = shift register MSB; w_valid = 1.
  - Each edge: shift left, fill with IDLE_LEVEL, counter decrements.
  - When counter == 0, the current cycle is the last data bit:
    - without the feature: frame_done = 1 this cycle;
    - next state is SHIFT with the new word if a transfer occurs this cycle (zero-gap back-to-back), else IDLE (w returns to IDLE_LEVEL, w_valid 0).
- Throughput: one word per WIDTH cycles (WIDTH+1 with the feature).
- Counter width: clog2(WIDTH); no wrap-around beyond WIDTH-1 is possible.
- busy = (state != IDLE).
- Downstream has no backpressure: the sequence detector consumes every bit.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - After the last data bit, the block enters PARITY for one cycle.
  - w = even parity of the accepted word (XOR reduction, captured at load); w_valid = 1.
  - frame_done and din_ready move to the PARITY cycle.
  - From PARITY: to SHIFT on transfer, else IDLE.
- When undefined:
  - PARITY state and parity flop are absent.
  - Frames are exactly WIDTH bits.

Decomposition:
- Shared package ser_pkg holds:
  - state typedef/localparams IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10;
  - default width constant SER_WIDTH_DEF=8.
- No sub-module; the shift register, counter and parity XOR are small enough to live inline in bit_serializer.

Test Plan:
1. Reset, then din=8'hB6 with din_valid for 1 cycle, WIDTH=8, IDLE_LEVEL=0 -> w = 1,0,1,1,0,1,1,0 over cycles 1..8 after accept; w_valid high exactly 8 cycles; frame_done only on cycle 8; then w=0, w_valid=0, din_ready=1.
2. din_valid held high with 8'hFF then 8'h00 -> 16 consecutive w_valid cycles, no gap; din_ready high only in IDLE and on bit-8 cycles; w = eight 1s then eight 0s.
3. din_valid pulsed with 8'h55 at bit 4 of a 8'hF0 frame -> word ignored (din_ready=0); w continues 1,1,1,1,0,0,0,0; no extra frame.
4. reset_n driven low during bit 3 of 8'hC3 -> w=0, w_valid=0, busy=0 immediately, no frame_done; after release, 8'hA5 serializes correctly as 1,0,1,0,0,1,0,1.
5. SER_PARITY_EN defined: 8'hB6 -> 9 bits, ninth = 1, frame_done on cycle 9; 8'h03 -> ninth = 0.
6. Integration with the sequence detector: serialize 8'h0E -> detector sees w = 0,0,0,0,1,1,1,0; z asserts on the cycles after the second and third consecutive 1 and drops after the trailing 0.
